// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: valid/ready intake from decode, registered IDEX_* payload to execute.
// Define IDEX_SKID_EN to add a skid entry that makes id_ready a flop output.
module idex_stage_reg #(
  parameter int RD_WIDTH        = 5,
  parameter int ALUOP_WIDTH     = 5,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SIMD_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic                       id_sel1,
  input  logic                       id_sel2,
  input  logic [ADDR_WIDTH-1:0]      id_nowpc,
  input  logic [DATA_WIDTH-1:0]      id_imm,
  input  logic [SIMD_DATA_WIDTH-1:0] id_rs1_data,
  input  logic [SIMD_DATA_WIDTH-1:0] id_rs2_data,
  input  logic [RD_WIDTH-1:0]        id_rs1_addr,
  input  logic [RD_WIDTH-1:0]        id_rs2_addr,
  input  logic [RD_WIDTH-1:0]        id_rd_addr,
  input  logic                       id_rd_we,
  input  logic [ALUOP_WIDTH-1:0]     id_aluop,
  input  logic                       ex_ready,
  input  logic                       flush,
  output logic                       IDEX_Valid,
  output logic                       IDEX_Sel1,
  output logic                       IDEX_Sel2,
  output logic [ADDR_WIDTH-1:0]      IDEX_NowPC,
  output logic [DATA_WIDTH-1:0]      IDEX_Imm,
  output logic [SIMD_DATA_WIDTH-1:0] IDEX_Rs1Data,
  output logic [SIMD_DATA_WIDTH-1:0] IDEX_Rs2Data,
  output logic [RD_WIDTH-1:0]        IDEX_Rs1Addr,
  output logic [RD_WIDTH-1:0]        IDEX_Rs2Addr,
  output logic [RD_WIDTH-1:0]        IDEX_RdAddr,
  output logic                       IDEX_RdWe,
  output logic [ALUOP_WIDTH-1:0]     IDEX_AluOp
);

  localparam int PW = 2 + ADDR_WIDTH + DATA_WIDTH + 2 * SIMD_DATA_WIDTH + 3 * RD_WIDTH + 1 + ALUOP_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e        state_r;
  state_e        state_s;
  logic [PW-1:0] in_s;
  logic [PW-1:0] main_r;
  logic [PW-1:0] main_s;
  logic          accept_s;
  logic          consume_s;

  assign in_s = {id_sel1, id_sel2, id_nowpc, id_imm, id_rs1_data, id_rs2_data,
                 id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we, id_aluop};

  assign {IDEX_Sel1, IDEX_Sel2, IDEX_NowPC, IDEX_Imm, IDEX_Rs1Data, IDEX_Rs2Data,
          IDEX_Rs1Addr, IDEX_Rs2Addr, IDEX_RdAddr, IDEX_RdWe, IDEX_AluOp} = main_r;

  assign IDEX_Valid = (state_r != ST_EMPTY);
  assign accept_s   = id_valid && id_ready;
  assign consume_s  = IDEX_Valid && ex_ready;

`ifdef IDEX_SKID_EN
  logic          ready_r;
  logic [PW-1:0] skid_r;
  logic [PW-1:0] skid_s;
  assign id_ready = ready_r;
`else
  // Without the skid entry a stalled execute stage must backpressure decode in the same cycle.
  assign id_ready = !IDEX_Valid || ex_ready;
`endif

  // Next-state and payload-load selection; flush overrides every other event.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
`ifdef IDEX_SKID_EN
    skid_s  = skid_r;
`endif
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = '0;
`ifdef IDEX_SKID_EN
      skid_s  = '0;
`endif
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s = ST_FULL;
            main_s  = in_s;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && consume_s) begin
            main_s = in_s;
          end else if (accept_s) begin
`ifdef IDEX_SKID_EN
            state_s = ST_SKID;
            skid_s  = in_s;
`else
            main_s  = in_s;
`endif
          end else if (consume_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_FULL;
          end
        end
`ifdef IDEX_SKID_EN
        ST_SKID: begin
          if (consume_s) begin
            state_s = ST_FULL;
            main_s  = skid_r;
          end else begin
            state_s = ST_SKID;
          end
        end
`endif
        default: begin
          state_s = ST_EMPTY;
          main_s  = '0;
        end
      endcase
    end
  end

  // State, payload and (with skid) the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      main_r  <= '0;
`ifdef IDEX_SKID_EN
      skid_r  <= '0;
      ready_r <= 1'b1;
`endif
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
`ifdef IDEX_SKID_EN
      skid_r  <= skid_s;
      ready_r <= (state_s != ST_SKID);
`endif
    end
  end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: driver randomizes decode/execute traffic, monitor checks
// every cycle against a queue-based occupancy model (follows IDEX_SKID_EN like the RTL).
module tb_idex_stage_reg;

  typedef struct packed {
    logic        sel1;
    logic        sel2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic        we;
    logic [4:0]  aluop;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic ex_ready = 1'b0;
  logic flush = 1'b0;
  logic id_ready;
  pl_t  drv = '0;
  pl_t  got_s;
  logic        IDEX_Valid, IDEX_Sel1, IDEX_Sel2, IDEX_RdWe;
  logic [31:0] IDEX_NowPC, IDEX_Imm;
  logic [63:0] IDEX_Rs1Data, IDEX_Rs2Data;
  logic [4:0]  IDEX_Rs1Addr, IDEX_Rs2Addr, IDEX_RdAddr, IDEX_AluOp;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  pl_t exp_q[$];
  pl_t shown = '0;
  logic exp_rdy, acc, con;

  always #5 clk = ~clk;

  idex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_sel1(drv.sel1), .id_sel2(drv.sel2), .id_nowpc(drv.pc), .id_imm(drv.imm),
    .id_rs1_data(drv.rs1d), .id_rs2_data(drv.rs2d), .id_rs1_addr(drv.rs1a),
    .id_rs2_addr(drv.rs2a), .id_rd_addr(drv.rda), .id_rd_we(drv.we), .id_aluop(drv.aluop),
    .ex_ready(ex_ready), .flush(flush), .IDEX_Valid(IDEX_Valid),
    .IDEX_Sel1(IDEX_Sel1), .IDEX_Sel2(IDEX_Sel2), .IDEX_NowPC(IDEX_NowPC), .IDEX_Imm(IDEX_Imm),
    .IDEX_Rs1Data(IDEX_Rs1Data), .IDEX_Rs2Data(IDEX_Rs2Data), .IDEX_Rs1Addr(IDEX_Rs1Addr),
    .IDEX_Rs2Addr(IDEX_Rs2Addr), .IDEX_RdAddr(IDEX_RdAddr), .IDEX_RdWe(IDEX_RdWe),
    .IDEX_AluOp(IDEX_AluOp)
  );

  assign got_s = {IDEX_Sel1, IDEX_Sel2, IDEX_NowPC, IDEX_Imm, IDEX_Rs1Data, IDEX_Rs2Data,
                  IDEX_Rs1Addr, IDEX_Rs2Addr, IDEX_RdAddr, IDEX_RdWe, IDEX_AluOp};

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic pl_t rand_pl();
    pl_t p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return p;
  endfunction

  // Model: the held instructions form a FIFO of capacity 2 (skid) or 1; ready follows occupancy.
  function automatic logic model_ready(input int n, input logic er);
`ifdef IDEX_SKID_EN
    return (n < 2);
`else
    return (n == 0) || er;
`endif
  endfunction

  // Monitor: update the scoreboard at each edge, then compare shortly after.
  always @(posedge clk) begin
    if (!rst_n || !mon_en) begin
      exp_q.delete();
      shown = '0;
    end else begin
      exp_rdy = model_ready(exp_q.size(), ex_ready);
      acc = id_valid && exp_rdy;
      con = (exp_q.size() > 0) && ex_ready;
      if (flush) begin
        exp_q.delete();
        shown = '0;
      end else begin
        if (con) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(drv);
        if (exp_q.size() > 0) shown = exp_q[0];
      end
      #2;
      chk("valid", {255'd0, IDEX_Valid}, {255'd0, exp_q.size() > 0});
      chk("payload", {41'd0, got_s}, {41'd0, shown});
      chk("id_ready", {255'd0, id_ready}, {255'd0, model_ready(exp_q.size(), ex_ready)});
    end
  end

  task automatic step(input logic v, input pl_t p, input logic er, input logic fl);
    @(negedge clk);
    id_valid = v;
    drv = p;
    ex_ready = er;
    flush = fl;
  endtask

  task automatic step_pc(input logic v, input logic [31:0] pc, input logic er, input logic fl);
    pl_t p;
    p = rand_pl();
    p.pc = pc;
    step(v, p, er, fl);
  endtask

  initial begin
    pl_t p;
    #3;
    chk("reset_valid", {255'd0, IDEX_Valid}, 256'd0);
    chk("reset_payload", {41'd0, got_s}, 256'd0);
    chk("reset_ready", {255'd0, id_ready}, 256'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // First instruction with known fields
    p = rand_pl();
    p.pc = 32'h8000_0000; p.imm = 32'h10; p.sel1 = 1'b1; p.sel2 = 1'b0;
    step(1'b1, p, 1'b1, 1'b0);
    @(posedge clk); #3;
    chk("first_pc", {224'd0, IDEX_NowPC}, {224'd0, 32'h8000_0000});
    chk("first_imm", {224'd0, IDEX_Imm}, {224'd0, 32'h10});
    chk("first_ready", {255'd0, id_ready}, 256'd1);

    // Back-to-back with no bubbles
    for (int i = 0; i < 3; i++) begin
      step_pc(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      @(posedge clk); #3;
      chk("b2b_pc", {224'd0, IDEX_NowPC}, {224'd0, 32'h100 + 32'(4 * i)});
      chk("b2b_valid", {255'd0, IDEX_Valid}, 256'd1);
    end
    step_pc(1'b0, 32'h0, 1'b1, 1'b0);
    step_pc(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef IDEX_SKID_EN
    step_pc(1'b1, 32'h200, 1'b0, 1'b0);
    step_pc(1'b1, 32'h204, 1'b0, 1'b0);
    step_pc(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #3;
    chk("skid_hold_pc", {224'd0, IDEX_NowPC}, {224'd0, 32'h200});
    chk("skid_ready", {255'd0, id_ready}, 256'd0);
    step_pc(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #3;
    chk("skid_next_pc", {224'd0, IDEX_NowPC}, {224'd0, 32'h204});
    step_pc(1'b1, 32'h300, 1'b0, 1'b0);
`else
    step_pc(1'b1, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; drv = rand_pl(); ex_ready = 1'b0;
    #1;
    chk("comb_ready_low", {255'd0, id_ready}, 256'd0);
    ex_ready = 1'b1;
    #1;
    chk("comb_ready_high", {255'd0, id_ready}, 256'd1);
`endif
    // Flush with an incoming instruction
    step_pc(1'b1, 32'h304, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("flush_valid", {255'd0, IDEX_Valid}, 256'd0);
    chk("flush_rdwe", {255'd0, IDEX_RdWe}, 256'd0);
    chk("flush_payload", {41'd0, got_s}, 256'd0);
    chk("flush_ready", {255'd0, id_ready}, 256'd1);

    // Async reset mid-stall
    step_pc(1'b1, 32'h400, 1'b0, 1'b0);
    step_pc(1'b1, 32'h404, 1'b0, 1'b0);
    step_pc(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("stall_valid", {255'd0, IDEX_Valid}, 256'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {255'd0, IDEX_Valid}, 256'd0);
    chk("arst_payload", {41'd0, got_s}, 256'd0);
    chk("arst_ready", {255'd0, id_ready}, 256'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, rand_pl(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 5);
    end
    step_pc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
# idex_stage_reg

ID/EX pipeline register of the core: accepts a decoded instruction from the decode stage over a valid/ready handshake and presents the registered `IDEX_*` operand-select, PC, immediate and register-data fields that the execute stage's ALU operand mux consumes. It is the producer side of the `IDEX_*` interface. It owns pipeline stall (backpressure from execute), bubble insertion and flush for this boundary. An optional skid entry breaks the combinational ready path from execute back to decode.

## Interface

Parameters:
- `RD_WIDTH`, 5: register-address width for rs1/rs2/rd.
- `ALUOP_WIDTH`, 5: ALU operation code width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode presents an instruction.
- `id_ready`  out  1  block can accept this cycle.
- `id_sel1`, `id_sel2`  in  1 each  operand selects (1 = register data, 0 = PC / immediate).
- `id_nowpc`  in  `ADDR_WIDTH`  instruction PC.
- `id_imm`  in  `DATA_WIDTH`  decoded immediate.
- `id_rs1_data`, `id_rs2_data`  in  `SIMD_DATA_WIDTH`  register-file read data.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  `RD_WIDTH`  register indices.
- `id_rd_we`  in  1  writeback enable.
- `id_aluop`  in  `ALUOP_WIDTH`  ALU op.
- `ex_ready`  in  1  execute consumes the current `IDEX_*` entry.
- `flush`  in  1  kill all held and incoming instructions.
- `IDEX_Valid`  out  1  `IDEX_*` payload is a live instruction.
- `IDEX_Sel1`, `IDEX_Sel2`, `IDEX_NowPC`, `IDEX_Imm`, `IDEX_Rs1Data`, `IDEX_Rs2Data`, `IDEX_Rs1Addr`, `IDEX_Rs2Addr`, `IDEX_RdAddr`, `IDEX_RdWe`, `IDEX_AluOp`  out  matching `id_*` widths  registered payload.

## Operation

- Accept: `id_valid && id_ready`.
- Consume: `IDEX_Valid && ex_ready`.
- States (with skid): EMPTY (no entry), FULL (main entry only), SKID (main and skid entries).
  - EMPTY: accept → FULL, payload loaded into main.
  - FULL: accept + consume → FULL, main reloaded. Accept only → SKID, incoming captured in skid. Consume only → EMPTY. Neither → hold.
  - SKID: consume → FULL, skid moved to main. No consume → hold.
- `id_ready` is registered and equals `state != SKID`.
- `IDEX_Valid` equals `state != EMPTY`.
- Payload registers change only on load or flush. All `IDEX_*` outputs hold stable while `IDEX_Valid && !ex_ready`.
- `flush` has priority over every other event:
  - Next state is EMPTY and the skid entry is discarded.
  - An instruction accepted in the same cycle is discarded.
  - All payload outputs are cleared to 0 (bubble), so `IDEX_RdWe` is 0.
- No arithmetic is performed. Fields pass through bit-exact; the SIMD data width is carried unmodified.

## Timing

- Reset (async assert, sync-safe deassert): state EMPTY, `IDEX_Valid`=0, every payload output 0, `id_ready`=1.
- Latency: an instruction accepted at edge N is visible on `IDEX_*` after edge N, valid in cycle N+1.
- Throughput: one instruction per cycle while `ex_ready`=1.
- Execute stalling: at most one further instruction is absorbed (skid), then `id_ready` drops the cycle after the SKID entry.
- Reset asserted mid-stall: both entries are lost immediately, with no partial outputs.

## Configuration

- `IDEX_SKID_EN` defined: skid entry and 3-state behaviour as above; `id_ready` is a flop output.
- `IDEX_SKID_EN` undefined: no skid entry; states EMPTY/FULL only.
  - `id_ready = !IDEX_Valid || ex_ready` (combinational).
  - Latency, payload, flush and reset behaviour are otherwise identical.

## Test plan

- Reset, then accept `id_nowpc`=0x80000000, `id_imm`=0x10, `id_sel1`=1, `id_sel2`=0 with `ex_ready`=1 → next cycle `IDEX_Valid`=1 and fields match; `id_ready` stays 1.
- Back-to-back PCs 0x100, 0x104, 0x108 with `ex_ready`=1 → `IDEX_NowPC` shows 0x100, 0x104, 0x108 on consecutive cycles, with no bubbles.
- With `IDEX_SKID_EN`: `ex_ready`=0 while sending 0x200 and 0x204 → `IDEX_NowPC` holds 0x200 and `id_ready`=0. Then `ex_ready`=1 → 0x204 follows the next cycle with no loss or duplication.
- `flush` in SKID state, simultaneous with `id_valid`=1 → next cycle `IDEX_Valid`=0, `IDEX_RdWe`=0, all payload 0, `id_ready`=1.
- Async `rst_n` low mid-stall with `IDEX_Valid`=1 → outputs cleared within the same cycle, without a clock edge.
- Without `IDEX_SKID_EN`: `IDEX_Valid`=1, `ex_ready`=0 → `id_ready`=0 combinationally. Raising `ex_ready` the same cycle → `id_ready`=1.
